td4_sequencer: RTL and testbench
================================

Name: td4_sequencer

Overview:
Fetch/execute controller for the 4-bit TTM4 CPU datapath. Holds the program counter, instruction register and carry flag. Decodes each 8-bit instruction (opcode[7:4], immediate[3:0]) into active-low output-enable and store strobes for register A, register B, the output port and the PC. These strobes drive the 74HC161/74AC125-style register blocks and bus buffers. It supports free-run and single-step execution for board debug.

Parameters:
PC_W, 4, program counter / ROM address width
OP_NOP_ON_UNDEF, 1, 1 = undefined opcodes execute as NOP; 0 = undefined opcodes halt the sequencer

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous reset, active-high
RUN  input  1  1 = free-run; 0 = halt after current instruction
STEP  input  1  one-cycle pulse; executes one instruction while halted
ROM_ADDR  output  PC_W  instruction address (= PC)
ROM_DATA  input  8  instruction from combinational ROM
ALU_CO  input  1  carry out of the adder (bus + IMM)
IMM  output  4  immediate field of IR, to ALU B operand
nA_OUT  output  1  register A onto bus, active-low
nB_OUT  output  1  register B onto bus, active-low
nIN_OUT  output  1  input port onto bus, active-low (none low = bus reads 0)
nA_ST  output  1  store ALU result into A, active-low
nB_ST  output  1  store into B, active-low
nOUT_ST  output  1  store into output port, active-low
nPC_LD  output  1  PC loaded from IMM this cycle, active-low (observation)
C_FLAG  output  1  carry flag
BUSY  output  1  1 while in FETCH or EXEC

Behaviour:
- Reset (RST=1 at edge): state=HALT, PC=0, IR=8'h00, C_FLAG=0. All n* strobes high, BUSY=0. Reset has priority over everything, including mid-instruction: no strobe completes.
- States: HALT, FETCH, EXEC. Two cycles per instruction.
- HALT: if RUN=1 or STEP=1 -> FETCH; else stay. STEP=1 while RUN=1 or while not in HALT is ignored.
- FETCH: ROM_ADDR=PC; IR<=ROM_DATA at end of cycle; -> EXEC. All strobes high.
- EXEC: bus enable and store strobes come combinationally from IR, low for exactly this one cycle. The register loads at the closing edge.
- EXEC closing edge:
  - C_FLAG<=ALU_CO for every instruction.
  - PC<=IMM if a jump is taken, else PC+1 mod 2^PC_W (F wraps to 0).
  - Next state: FETCH if RUN=1, else HALT.
- Decode (opcode: source enable / store / note):
  - 0000 ADD A,Im: nA_OUT / nA_ST
  - 0101 ADD B,Im: nB_OUT / nB_ST
  - 0011 MOV A,Im: none / nA_ST
  - 0111 MOV B,Im: none / nB_ST
  - 0001 MOV A,B: nB_OUT / nA_ST (IMM forced 0)
  - 0100 MOV B,A: nA_OUT / nB_ST (IMM forced 0)
  - 0010 IN A: nIN_OUT / nA_ST (IMM forced 0)
  - 0110 IN B: nIN_OUT / nB_ST (IMM forced 0)
  - 1001 OUT B: nB_OUT / nOUT_ST (IMM forced 0)
  - 1011 OUT Im: none / nOUT_ST
  - 1111 JMP Im: none / nPC_LD, always taken
  - 1110 JNC Im: none / nPC_LD only if C_FLAG=0. Uses the flag value from before this EXEC.
- IMM = IR[3:0] except where noted as forced 0. It is 0 outside EXEC.
- At most one of nA_OUT/nB_OUT/nIN_OUT is low at any time. At most one of nA_ST/nB_ST/nOUT_ST is low at any time.
- Undefined opcode: all strobes high. With OP_NOP_ON_UNDEF=1, PC increments. With OP_NOP_ON_UNDEF=0, PC holds, state -> HALT, and it re-executes on the next STEP/RUN.
- RUN deasserted during FETCH: the current instruction still completes its EXEC, then the sequencer enters HALT.

Test Plan:
- Reset then RUN=1, ROM[0]=8'h35 (MOV A,5): FETCH at cycle 1, EXEC at cycle 2 with nA_ST=0 and IMM=5, other strobes high; ROM_ADDR=1 at cycle 3.
- ROM[0]=8'h0F with ALU_CO=1 in EXEC, ROM[1]=8'hE7 (JNC 7): C_FLAG=1, JNC not taken, PC=2, nPC_LD high. Repeat with ALU_CO=0: PC=7, nPC_LD=0.
- ROM[F]=8'hF3 at PC=F: PC=3. ROM[F]=8'h00 at PC=F: PC wraps to 0.
- RUN=0, three STEP pulses 5 cycles apart: exactly three instructions executed, PC=3, BUSY high for 2 cycles after each STEP.
- RST asserted during EXEC of OUT B (8'h90): nOUT_ST high that cycle, PC=0, C_FLAG=0, state HALT.
- ROM[0]=8'h80 (undefined): OP_NOP_ON_UNDEF=1 gives no strobes and PC=1; OP_NOP_ON_UNDEF=0 gives PC=0, state HALT.

Source files
------------

// File: rtl/td4_sequencer.sv
// Fetch/execute controller for the 4-bit TTM4 CPU: PC, IR and carry flag,
// with active-low bus-enable and store strobes decoded from the IR.
module td4_sequencer #(
  parameter int PC_W            = 4,
  parameter bit OP_NOP_ON_UNDEF = 1'b1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            RUN,
  input  logic            STEP,
  output logic [PC_W-1:0] ROM_ADDR,
  input  logic [7:0]      ROM_DATA,
  input  logic            ALU_CO,
  output logic [3:0]      IMM,
  output logic            nA_OUT,
  output logic            nB_OUT,
  output logic            nIN_OUT,
  output logic            nA_ST,
  output logic            nB_ST,
  output logic            nOUT_ST,
  output logic            nPC_LD,
  output logic            C_FLAG,
  output logic            BUSY
);

  typedef enum logic [1:0] {S_HALT, S_FETCH, S_EXEC} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [PC_W-1:0] pc;
  logic [7:0]      ir;
  logic            c_flag;

  logic src_a, src_b, src_in;
  logic st_a, st_b, st_out;
  logic jmp_taken, imm_zero, undef;
  logic exec_act;

  // Instruction decode from the IR; gated to the EXEC cycle at the outputs.
  always_comb begin
    src_a     = 1'b0;
    src_b     = 1'b0;
    src_in    = 1'b0;
    st_a      = 1'b0;
    st_b      = 1'b0;
    st_out    = 1'b0;
    jmp_taken = 1'b0;
    imm_zero  = 1'b0;
    undef     = 1'b0;
    case (ir[7:4])
      4'b0000: begin src_a  = 1'b1; st_a   = 1'b1; end
      4'b0101: begin src_b  = 1'b1; st_b   = 1'b1; end
      4'b0011: begin st_a   = 1'b1; end
      4'b0111: begin st_b   = 1'b1; end
      4'b0001: begin src_b  = 1'b1; st_a   = 1'b1; imm_zero = 1'b1; end
      4'b0100: begin src_a  = 1'b1; st_b   = 1'b1; imm_zero = 1'b1; end
      4'b0010: begin src_in = 1'b1; st_a   = 1'b1; imm_zero = 1'b1; end
      4'b0110: begin src_in = 1'b1; st_b   = 1'b1; imm_zero = 1'b1; end
      4'b1001: begin src_b  = 1'b1; st_out = 1'b1; imm_zero = 1'b1; end
      4'b1011: begin st_out = 1'b1; end
      4'b1111: begin jmp_taken = 1'b1; end
      // JNC looks at the flag as it stood before this EXEC.
      4'b1110: begin jmp_taken = ~c_flag; end
      default: begin undef = 1'b1; end
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_HALT;
      pc     <= '0;
      ir     <= 8'h00;
      c_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        ir <= ROM_DATA;
      end
      if (state == S_EXEC) begin
        c_flag <= ALU_CO;
        if (jmp_taken) begin
          pc <= PC_W'(ir[3:0]);
        end else if (!(undef && !OP_NOP_ON_UNDEF)) begin
          pc <= pc + PC_W'(1);
        end
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALT:  if (RUN || STEP) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_EXEC;
      S_EXEC: begin
        if (undef && !OP_NOP_ON_UNDEF) state_nxt = S_HALT;
        else if (RUN)                  state_nxt = S_FETCH;
        else                           state_nxt = S_HALT;
      end
      default: state_nxt = S_HALT;
    endcase
  end

  // Strobes are suppressed while reset is asserted so no store completes.
  always_comb begin
    exec_act = (state == S_EXEC) && !RST;
    ROM_ADDR = pc;
    C_FLAG   = c_flag;
    BUSY     = (state != S_HALT);
    IMM      = (exec_act && !imm_zero) ? ir[3:0] : 4'h0;
    nA_OUT   = ~(exec_act && src_a);
    nB_OUT   = ~(exec_act && src_b);
    nIN_OUT  = ~(exec_act && src_in);
    nA_ST    = ~(exec_act && st_a);
    nB_ST    = ~(exec_act && st_b);
    nOUT_ST  = ~(exec_act && st_out);
    nPC_LD   = ~(exec_act && jmp_taken);
  end

endmodule

// File: tb/tb_td4_sequencer.sv
// Scoreboard bench for td4_sequencer: directed programs push expected EXEC
// results; a monitor pops and compares on every EXEC cycle.
module tb_td4_sequencer;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST = 1'b1, RUN = 1'b0, STEP = 1'b0, RUN2 = 1'b0, STEP2 = 1'b0;
  logic alu_co = 1'b0;
  logic [7:0] rom [16];

  logic [3:0] addr, addr2, imm, imm2;
  logic [7:0] rom_data, rom_data2;
  logic nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD, C_FLAG, BUSY;
  logic nA_OUT2, nB_OUT2, nIN_OUT2, nA_ST2, nB_ST2, nOUT_ST2, nPC_LD2, C_FLAG2, BUSY2;
  logic [6:0] stb, stb2;

  assign rom_data  = rom[addr];
  assign rom_data2 = rom[addr2];
  assign stb  = {nA_OUT, nB_OUT, nIN_OUT, nA_ST, nB_ST, nOUT_ST, nPC_LD};
  assign stb2 = {nA_OUT2, nB_OUT2, nIN_OUT2, nA_ST2, nB_ST2, nOUT_ST2, nPC_LD2};

  td4_sequencer #(.PC_W(4), .OP_NOP_ON_UNDEF(1'b1)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .STEP(STEP), .ROM_ADDR(addr),
    .ROM_DATA(rom_data), .ALU_CO(alu_co), .IMM(imm), .nA_OUT(nA_OUT),
    .nB_OUT(nB_OUT), .nIN_OUT(nIN_OUT), .nA_ST(nA_ST), .nB_ST(nB_ST),
    .nOUT_ST(nOUT_ST), .nPC_LD(nPC_LD), .C_FLAG(C_FLAG), .BUSY(BUSY)
  );

  td4_sequencer #(.PC_W(4), .OP_NOP_ON_UNDEF(1'b0)) dut_halt (
    .CLK(CLK), .RST(RST), .RUN(RUN2), .STEP(STEP2), .ROM_ADDR(addr2),
    .ROM_DATA(rom_data2), .ALU_CO(alu_co), .IMM(imm2), .nA_OUT(nA_OUT2),
    .nB_OUT(nB_OUT2), .nIN_OUT(nIN_OUT2), .nA_ST(nA_ST2), .nB_ST(nB_ST2),
    .nOUT_ST(nOUT_ST2), .nPC_LD(nPC_LD2), .C_FLAG(C_FLAG2), .BUSY(BUSY2)
  );

  typedef struct packed {
    logic [6:0] stb;
    logic [3:0] imm;
    logic [3:0] pc;
    logic       c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [6:0] s, input logic [3:0] i, input logic [3:0] p, input logic c);
    exp_t e;
    e = {s, i, p, c};
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge CLK);
    #2;
  endtask

  task automatic do_reset;
    RST = 1'b1; RUN = 1'b0; STEP = 1'b0; RUN2 = 1'b0; STEP2 = 1'b0;
    tick();
    RST = 1'b0;
  endtask

  // Run n instructions from HALT, dropping RUN during the last FETCH.
  task automatic run_n(input int n);
    RUN = 1'b1;
    repeat (2 * n - 1) tick();
    RUN = 1'b0;
    repeat (2) tick();
  endtask

  task automatic clear_rom;
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Monitor: tracks FETCH/EXEC phase from BUSY and checks each EXEC.
  initial begin
    bit   phase;
    exp_t e;
    phase = 1'b0;
    forever begin
      @(negedge CLK);
      if (RST) begin
        phase = 1'b0;
      end else if (BUSY) begin
        if (!phase) begin
          phase = 1'b1;
        end else begin
          phase = 1'b0;
          if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL exec_unexpected: got EXEC strobes %0h, required no EXEC", stb);
          end else begin
            e = q.pop_front();
            chk("exec_strobes", 32'(stb), 32'(e.stb));
            chk("exec_imm", 32'(imm), 32'(e.imm));
            @(posedge CLK);
            #1;
            chk("next_pc", 32'(addr), 32'(e.pc));
            chk("c_flag", 32'(C_FLAG), 32'(e.c));
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required end of test");
    $fatal(1);
  end

  initial begin
    clear_rom();
    do_reset();
    chk("rst_addr", 32'(addr), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_strobes", 32'(stb), 32'h7F);
    chk("rst_imm", 32'(imm), 32'h0);
    chk("rst_cflag", 32'(C_FLAG), 32'h0);

    // MOV A,5 with cycle-level FETCH checks
    rom[0] = 8'h35;
    push(7'b1110111, 4'h5, 4'h1, 1'b0);
    RUN = 1'b1;
    tick();
    chk("fetch_busy", 32'(BUSY), 32'h1);
    chk("fetch_strobes", 32'(stb), 32'h7F);
    chk("fetch_addr", 32'(addr), 32'h0);
    RUN = 1'b0;
    tick();
    tick();
    chk("halt_after_run_drop", 32'(BUSY), 32'h0);

    // ADD A,F with carry, then JNC 7 not taken
    do_reset(); clear_rom();
    rom[0] = 8'h0F; rom[1] = 8'hE7; alu_co = 1'b1;
    push(7'b0110111, 4'hF, 4'h1, 1'b1);
    push(7'b1111111, 4'h7, 4'h2, 1'b1);
    run_n(2);

    // Same program without carry: JNC taken
    do_reset(); alu_co = 1'b0;
    push(7'b0110111, 4'hF, 4'h1, 1'b0);
    push(7'b1111110, 4'h7, 4'h7, 1'b0);
    run_n(2);

    // JMP F then JMP 3 at PC=F
    do_reset(); clear_rom();
    rom[0] = 8'hFF; rom[15] = 8'hF3;
    push(7'b1111110, 4'hF, 4'hF, 1'b0);
    push(7'b1111110, 4'h3, 4'h3, 1'b0);
    run_n(2);

    // JMP F then ADD A,0 at PC=F: PC wraps
    do_reset();
    rom[15] = 8'h00;
    push(7'b1111110, 4'hF, 4'hF, 1'b0);
    push(7'b0110111, 4'h0, 4'h0, 1'b0);
    run_n(2);

    // Register moves and input-port sources
    do_reset(); clear_rom();
    rom[0] = 8'h53; rom[1] = 8'h1F; rom[2] = 8'h6F; rom[3] = 8'h3C;
    push(7'b1011011, 4'h3, 4'h1, 1'b0);
    push(7'b1010111, 4'h0, 4'h2, 1'b0);
    push(7'b1101011, 4'h0, 4'h3, 1'b0);
    push(7'b1110111, 4'hC, 4'h4, 1'b0);
    run_n(4);

    // Single-step: three STEP pulses five cycles apart
    do_reset(); clear_rom();
    rom[0] = 8'h4C; rom[1] = 8'h9D; rom[2] = 8'h2E;
    push(7'b0111011, 4'h0, 4'h1, 1'b0);
    push(7'b1011101, 4'h0, 4'h2, 1'b0);
    push(7'b1100111, 4'h0, 4'h3, 1'b0);
    for (int k = 0; k < 3; k++) begin
      STEP = 1'b1;
      tick();
      STEP = 1'b0;
      chk("step_busy_fetch", 32'(BUSY), 32'h1);
      tick();
      chk("step_busy_exec", 32'(BUSY), 32'h1);
      tick();
      chk("step_busy_halt", 32'(BUSY), 32'h0);
      tick();
      tick();
    end
    chk("step_final_pc", 32'(addr), 32'h3);

    // Reset during EXEC of OUT B
    do_reset(); clear_rom();
    rom[0] = 8'h90; alu_co = 1'b1;
    RUN = 1'b1;
    tick();
    RUN = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    chk("rst_exec_nout_st", 32'(nOUT_ST), 32'h1);
    chk("rst_exec_nb_out", 32'(nB_OUT), 32'h1);
    tick();
    RST = 1'b0;
    alu_co = 1'b0;
    chk("rst_exec_pc", 32'(addr), 32'h0);
    chk("rst_exec_cflag", 32'(C_FLAG), 32'h0);
    chk("rst_exec_busy", 32'(BUSY), 32'h0);
    tick();
    chk("rst_exec_stays_halt", 32'(BUSY), 32'h0);

    // Undefined opcode executes as NOP
    do_reset(); clear_rom();
    rom[0] = 8'h80;
    push(7'b1111111, 4'h0, 4'h1, 1'b0);
    run_n(1);

    // Undefined opcode halts the sequencer when not treated as NOP
    do_reset();
    RUN2 = 1'b1;
    tick();
    RUN2 = 1'b0;
    tick();
    chk("undef_halt_strobes", 32'(stb2), 32'h7F);
    chk("undef_halt_imm", 32'(imm2), 32'h0);
    tick();
    chk("undef_halt_pc", 32'(addr2), 32'h0);
    chk("undef_halt_busy", 32'(BUSY2), 32'h0);
    chk("undef_halt_cflag", 32'(C_FLAG2), 32'h0);
    STEP2 = 1'b1;
    tick();
    STEP2 = 1'b0;
    chk("undef_restep_busy", 32'(BUSY2), 32'h1);
    tick();
    tick();
    chk("undef_restep_pc", 32'(addr2), 32'h0);
    chk("undef_restep_halt", 32'(BUSY2), 32'h0);

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
